regfile_wb_sched: RTL and testbench

//  Write-back scheduler and scoreboard for the 2R/1W register file.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/regfile_wb_sched.sv | 151 +++++++++++++++
 tb/tb_regfile_wb_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the write-back path.
package regfile_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    // r0 is hard-wired to zero and is never written.
    localparam reg_addr_t R0 = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr (wrapping modulo N) wins.
module rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan from ptr upward, wrapping; the first hit takes the grant.
    always_comb begin
        int unsigned j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (32'(ptr) + i) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and pending-write scoreboard for the 2R/1W register file.
// Round-robin shares the single write port; pending bits let issue stall on RAW/WAW.
module regfile_wb_sched #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DATA_W  = regfile_pkg::DATA_W,
    parameter int unsigned ADDR_W  = regfile_pkg::ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      rsv_valid,
    input  logic [ADDR_W-1:0]         rsv_addr,
    output logic                      rsv_ready,
    input  logic [ADDR_W-1:0]         chk_addr_a,
    input  logic [ADDR_W-1:0]         chk_addr_b,
    output logic                      busy_a,
    output logic                      busy_b,
    output logic                      write_enable,
    output logic [ADDR_W-1:0]         write_addr,
    output logic [DATA_W-1:0]         write_data,
    output logic                      err_unexp
);

    localparam int unsigned IDX_W    = $clog2(NUM_REQ);
    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0]  gnt;
    logic                hs;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_nz;

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic                rsv_acc;
    logic                err_q, err_d;

    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (hs)
    );

    // The grant only ever goes to a valid requester, so any grant is a handshake.
    assign req_ready = gnt;

    // Select the granted requester's destination and result.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_nz = (sel_addr != '0);

    // Pointer moves just past the winner after a handshake, otherwise holds.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (hs) begin
            rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
    end

    // Scoreboard next state: clear on write-back, then set on reservation so set wins.
    always_comb begin
        pending_d = pending_q;
        if (hs && sel_nz) begin
            pending_d[sel_addr] = 1'b0;
        end
        if (rsv_acc && (rsv_addr != '0)) begin
            pending_d[rsv_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    assign rsv_ready = rsv_valid & ~pending_q[rsv_addr];
    assign rsv_acc   = rsv_ready;
    assign busy_a    = pending_q[chk_addr_a];
    assign busy_b    = pending_q[chk_addr_b];

    // Sticky flag for a write-back nobody reserved.
    assign err_d = err_q | (hs & sel_nz & ~pending_q[sel_addr]);

    // Output stage next state: r0 handshakes are swallowed and leave addr/data untouched.
    always_comb begin
        we_d    = hs & sel_nz;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (hs && sel_nz) begin
            waddr_d = sel_addr;
            wdata_d = sel_data;
        end
    end

    // Arbitration pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Pending bits and the sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q <= '0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    // Registered write port toward the regfile.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign write_enable = we_q;
    assign write_addr   = waddr_q;
    assign write_data   = wdata_q;
    assign err_unexp    = err_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;
    import regfile_pkg::*;

    localparam int unsigned NREQ = 3;
    localparam int unsigned AW   = regfile_pkg::ADDR_W;
    localparam int unsigned DW   = regfile_pkg::DATA_W;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*AW-1:0]     req_addr;
    logic [NREQ*DW-1:0]     req_data;
    logic                   rsv_valid;
    logic [AW-1:0]          rsv_addr;
    logic                   rsv_ready;
    logic [AW-1:0]          chk_addr_a;
    logic [AW-1:0]          chk_addr_b;
    logic                   busy_a;
    logic                   busy_b;
    logic                   write_enable;
    logic [AW-1:0]          write_addr;
    logic [DW-1:0]          write_data;
    logic                   err_unexp;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;
    logic [AW+DW-1:0] exp_q[$];
    reg_data_t rf [2**AW];

    regfile_wb_sched #(
        .NUM_REQ (NREQ),
        .DATA_W  (DW),
        .ADDR_W  (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .rsv_valid    (rsv_valid),
        .rsv_addr     (rsv_addr),
        .rsv_ready    (rsv_ready),
        .chk_addr_a   (chk_addr_a),
        .chk_addr_b   (chk_addr_b),
        .busy_a       (busy_a),
        .busy_b       (busy_b),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .err_unexp    (err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple regfile model fed by the write port.
    always @(posedge clk) begin
        if (write_enable) rf[write_addr] <= write_data;
    end

    // Monitor: every write on the port must match the next expected entry.
    always @(negedge clk) begin
        if (mon_en && rst && write_enable) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%0d, required no write",
                         write_addr, write_data);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                if ({write_addr, write_data} !== e) begin
                    errors++;
                    $display("FAIL write_port: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             write_addr, write_data, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int g, input int a, input int d);
        req_addr[g*AW +: AW] = AW'(a);
        req_data[g*DW +: DW] = DW'(d);
    endtask

    task automatic push_exp(input int a, input int d);
        exp_q.push_back({AW'(a), DW'(d)});
    endtask

    initial begin
        rst        = 1'b0;
        req_valid  = '0;
        req_addr   = '0;
        req_data   = '0;
        rsv_valid  = 1'b0;
        rsv_addr   = '0;
        chk_addr_a = '0;
        chk_addr_b = '0;

        // 1: reset state, then reset mid-stream
        tick();
        chk("rst_we", 64'(write_enable), 64'd0);
        chk("rst_err", 64'(err_unexp), 64'd0);
        rst = 1'b1;
        tick();
        rsv_valid = 1'b1;
        rsv_addr  = 5;
        settle();
        chk("t1_rsv_ready", 64'(rsv_ready), 64'd1);
        tick();
        rsv_valid  = 1'b0;
        chk_addr_a = 5;
        set_req(0, 1, 11);
        set_req(1, 2, 22);
        set_req(2, 3, 33);
        req_valid = 3'b111;
        settle();
        chk("t1_busy_a", 64'(busy_a), 64'd1);
        chk("t1_ready0", 64'(req_ready), 64'b001);
        tick();
        chk("t1_we_inflight", 64'(write_enable), 64'd1);
        chk("t1_err_set", 64'(err_unexp), 64'd1);
        chk("t1_ready_rot", 64'(req_ready), 64'b010);
        rst = 1'b0;
        settle();
        chk("t1_we_dropped", 64'(write_enable), 64'd0);
        chk("t1_err_clr", 64'(err_unexp), 64'd0);
        chk("t1_busy_a_clr", 64'(busy_a), 64'd0);
        chk("t1_busy_b_clr", 64'(busy_b), 64'd0);
        rst = 1'b1;
        settle();
        chk("t1_ready_after", 64'(req_ready), 64'b001);
        req_valid = '0;
        mon_en    = 1'b1;

        // 2: single reserved write of r7
        tick();
        rsv_valid = 1'b1;
        rsv_addr  = 7;
        settle();
        chk("t2_rsv_ready", 64'(rsv_ready), 64'd1);
        tick();
        rsv_valid  = 1'b0;
        chk_addr_a = 7;
        set_req(0, 7, 327);
        req_valid = 3'b001;
        settle();
        chk("t2_busy_before", 64'(busy_a), 64'd1);
        chk("t2_ready", 64'(req_ready), 64'b001);
        push_exp(7, 327);
        tick();
        req_valid = '0;
        settle();
        chk("t2_busy_after", 64'(busy_a), 64'd0);
        tick();
        chk("t2_rf_r7", 64'(rf[7]), 64'd327);

        // 5a: r0 write is accepted but never reaches the port (pointer is 1 here)
        set_req(2, 0, 5);
        req_valid = 3'b100;
        settle();
        chk("t5_r0_ready", 64'(req_ready), 64'b100);
        tick();
        req_valid = '0;
        settle();
        chk("t5_r0_no_we", 64'(write_enable), 64'd0);

        // 3: fairness with all three valid, pointer back at 0
        for (int k = 0; k < 6; k++) begin
            rsv_valid = 1'b1;
            rsv_addr  = AW'(10 + k);
            settle();
            chk("t3_rsv_ready", 64'(rsv_ready), 64'd1);
            tick();
        end
        rsv_valid = 1'b0;
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            int g;
            g = k % 3;
            set_req(g, 10 + k, 1000 + k);
            settle();
            chk($sformatf("t3_grant%0d", k), 64'(req_ready), 64'(1 << g));
            push_exp(10 + k, 1000 + k);
            tick();
        end
        req_valid = '0;
        settle();
        chk("t3_err_clean", 64'(err_unexp), 64'd0);

        // 4a: WAW stall on r3, write-back while the stalled reservation is held
        rsv_valid  = 1'b1;
        rsv_addr   = 3;
        chk_addr_b = 3;
        settle();
        chk("t4_rsv_first", 64'(rsv_ready), 64'd1);
        tick();
        chk("t4_waw_stall", 64'(rsv_ready), 64'd0);
        chk("t4_busy_b", 64'(busy_b), 64'd1);
        tick();
        set_req(0, 3, 36827);
        req_valid = 3'b001;
        settle();
        chk("t4_stall_wb", 64'(rsv_ready), 64'd0);
        chk("t4_wb_ready", 64'(req_ready), 64'b001);
        push_exp(3, 36827);
        tick();
        req_valid = '0;
        settle();
        chk("t4_err_clean", 64'(err_unexp), 64'd0);
        chk("t4_rsv_unstall", 64'(rsv_ready), 64'd1);
        tick();
        rsv_valid = 1'b0;
        settle();
        chk("t4_busy_reset", 64'(busy_b), 64'd1);

        // 5b: write-back to unreserved r9 raises the sticky error
        set_req(1, 9, 99);
        req_valid = 3'b010;
        settle();
        chk("t5_r9_ready", 64'(req_ready), 64'b010);
        chk("t5_err_before", 64'(err_unexp), 64'd0);
        push_exp(9, 99);
        tick();
        req_valid = '0;
        settle();
        chk("t5_err_set", 64'(err_unexp), 64'd1);
        repeat (3) tick();
        chk("t5_err_sticky", 64'(err_unexp), 64'd1);

        // 4b: same-cycle set and clear of r4, set wins
        chk_addr_a = 4;
        set_req(0, 4, 44);
        req_valid = 3'b001;
        rsv_valid = 1'b1;
        rsv_addr  = 4;
        settle();
        chk("t4b_rsv_ready", 64'(rsv_ready), 64'd1);
        chk("t4b_busy_pre", 64'(busy_a), 64'd0);
        push_exp(4, 44);
        tick();
        req_valid = '0;
        rsv_valid = 1'b0;
        settle();
        chk("t4b_set_wins", 64'(busy_a), 64'd1);
        chk("t4b_chk_r0", 64'(dut.busy_a & (chk_addr_a == R0)), 64'd0);

        repeat (3) tick();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
